lfsr_share_ctrl: RTL and testbench

Sequencer and round-robin arbiter that shares one 16-bit pseudo-random generator among NREQ requesters. Each requester asks for a burst of 1–16 random words. The block grants one requester at a time, steps the shared LFSR once per delivered word, and tags each word with the owner's index. It also handles reseeding, including the rule that a generator state of zero is never allowed. It sits between the LFSR datapath and the client blocks that consume random numbers.

---
 rtl/lfsr_share_ctrl.sv | 111 +++++++++++
 tb/tb_lfsr_share_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_share_ctrl.sv
// lfsr_share_ctrl
// Shares one Galois LFSR among NREQ requesters. A round-robin arbiter grants
// one requester at a time for a burst of 1..16 words, and the LFSR steps once
// per delivered word. Seeds are only accepted while idle, and a zero seed is
// replaced by SEED so that the generator can never lock up at zero.

module lfsr_share_ctrl #(
  parameter int WIDTH = 16,
  parameter int NREQ = 4,
  parameter logic [WIDTH-1:0] TAPS = 16'hB400,
  parameter logic [WIDTH-1:0] SEED = 16'hACE1,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] len,
  input  logic              seed_load,
  input  logic [WIDTH-1:0]  seed_val,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              q_valid,
  output logic [WIDTH-1:0]  q_data,
  output logic [IDW-1:0]    q_id,
  output logic              done
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]       fsm;
  logic [WIDTH-1:0] lfsrState;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   qIdReg;
  logic [NREQ-1:0]  grantReg;
  logic [4:0]       beatCnt;

  logic             found;
  logic [IDW-1:0]   winner;
  int               idx;
  logic [3:0]       winLen;
  logic [4:0]       winBeats;
  logic [WIDTH-1:0] stepped;
  logic [IDW-1:0]   nextPtr;

  // Round-robin search: scan from ptr upwards with wrap, first active req wins
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  // Burst length of the winner; a zero field means a full 16-word burst
  always_comb begin
    winLen   = len[4*winner +: 4];
    winBeats = (winLen == 4'd0) ? 5'd16 : {1'b0, winLen};
  end

  // Next LFSR value (Galois form) and the pointer position after the owner
  always_comb begin
    stepped = (lfsrState >> 1) ^ (lfsrState[0] ? TAPS : '0);
    nextPtr = (qIdReg == IDW'(NREQ - 1)) ? '0 : qIdReg + 1'b1;
  end

  // Sequencer: seed loads and arbitration in IDLE, one word per cycle in BURST
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fsm       <= IDLE;
      lfsrState <= SEED;
      ptr       <= '0;
      grantReg  <= '0;
      qIdReg    <= '0;
      beatCnt   <= '0;
    end else if (fsm == IDLE) begin
      if (seed_load) begin
        lfsrState <= (seed_val == '0) ? SEED : seed_val;
      end else if (found) begin
        fsm      <= BURST;
        grantReg <= NREQ'(1) << winner;
        qIdReg   <= winner;
        beatCnt  <= winBeats;
      end
    end else begin
      lfsrState <= stepped;
      beatCnt   <= beatCnt - 5'd1;
      if (beatCnt == 5'd1) begin
        fsm      <= IDLE;
        grantReg <= '0;
        ptr      <= nextPtr;
      end
    end
  end

  // All outputs come straight from registered state
  always_comb begin
    busy    = (fsm == BURST);
    q_valid = (fsm == BURST);
    done    = (fsm == BURST) && (beatCnt == 5'd1);
    q_data  = lfsrState;
    q_id    = qIdReg;
    grant   = grantReg;
  end

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// tb_lfsr_share_ctrl
// Self-checking bench: expected words are pushed into a scoreboard queue when
// a burst is requested and popped by a monitor on every valid output cycle.

module tb_lfsr_share_ctrl;

  localparam int NREQ = 4;
  localparam int IDW = 2;
  localparam logic [15:0] TAPS = 16'hB400;
  localparam logic [15:0] SEED = 16'hACE1;

  logic CLK = 1'b0;
  logic RESET;
  logic [NREQ-1:0] req;
  logic [4*NREQ-1:0] len;
  logic seed_load;
  logic [15:0] seed_val;
  logic [NREQ-1:0] grant;
  logic busy;
  logic q_valid;
  logic [15:0] q_data;
  logic [IDW-1:0] q_id;
  logic done;

  int checks = 0;
  int fails = 0;
  int validCount = 0;
  int doneCount = 0;

  typedef struct {
    logic [15:0] data;
    int id;
    logic last;
  } beat_t;

  typedef struct {
    logic [3:0] reqMask;
    logic [15:0] lenVec;
    int expId;
    int expLen;
  } vec_t;

  beat_t sbq[$];
  vec_t vecs[6];
  logic [15:0] modelState;

  lfsr_share_ctrl #(.WIDTH(16), .NREQ(NREQ), .TAPS(TAPS), .SEED(SEED)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .len(len),
    .seed_load(seed_load), .seed_val(seed_val),
    .grant(grant), .busy(busy), .q_valid(q_valid),
    .q_data(q_data), .q_id(q_id), .done(done)
  );

  // Free-running clock
  always #5 CLK = ~CLK;

  // Hard stop in case something hangs
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [15:0] lfsrStep(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 16'h0000);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [15:0] l,
                               input logic sl, input logic [15:0] sv);
    req = r;
    len = l;
    seed_load = sl;
    seed_val = sv;
  endtask

  task automatic pushBurst(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      sbq.push_back('{data: modelState, id: id, last: (k == n - 1)});
      modelState = lfsrStep(modelState);
    end
  endtask

  task automatic drainQueue(input string name);
    int c;
    c = 0;
    while (sbq.size() != 0 && c < 40) begin
      tick();
      c++;
    end
    checkOutput(name, 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  // Monitor: compare each delivered word against the scoreboard
  always @(negedge CLK) begin
    beat_t b;
    checkOutput("busy_eq_valid", 32'(busy), 32'(q_valid));
    if (q_valid) begin
      validCount++;
      if (done) doneCount++;
      if (sbq.size() == 0) begin
        checkOutput("unexpected_word", 32'(q_data), 32'hFFFF_FFFF);
      end else begin
        b = sbq.pop_front();
        checkOutput("q_data", 32'(q_data), 32'(b.data));
        checkOutput("q_id", 32'(q_id), 32'(b.id));
        checkOutput("grant_word", 32'(grant), 32'(NREQ'(1) << b.id));
        checkOutput("done", 32'(done), 32'(b.last));
      end
    end else begin
      checkOutput("idle_grant", 32'(grant), 32'd0);
      checkOutput("idle_done", 32'(done), 32'd0);
    end
  end

  initial begin
    int v0;
    int d0;
    vecs[0] = '{4'b0100, 16'h0000, 2, 16};
    vecs[1] = '{4'b0011, 16'h0046, 0, 6};
    vecs[2] = '{4'b1010, 16'h1070, 1, 7};
    vecs[3] = '{4'b1000, 16'h0000, 3, 16};
    vecs[4] = '{4'b0110, 16'h0210, 1, 1};
    vecs[5] = '{4'b1001, 16'h2003, 3, 2};

    RESET = 1'b1;
    applyStimulus(4'b0000, 16'h0000, 1'b0, 16'h0000);
    tick();
    tick();
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(q_valid), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_q_id", 32'(q_id), 32'd0);
    checkOutput("rst_q_data", 32'(q_data), 32'hACE1);
    RESET = 1'b0;

    // First burst after reset: fixed known words
    applyStimulus(4'b0001, 16'h0003, 1'b0, 16'h0000);
    sbq.push_back('{data: 16'hACE1, id: 0, last: 1'b0});
    sbq.push_back('{data: 16'hE270, id: 0, last: 1'b0});
    sbq.push_back('{data: 16'h7138, id: 0, last: 1'b1});
    modelState = lfsrStep(16'h7138);
    tick();
    checkOutput("seq1_grant", 32'(grant), 32'b0001);
    applyStimulus(4'b0000, 16'h0003, 1'b0, 16'h0000);
    drainQueue("seq1_drain");
    tick();
    checkOutput("seq1_after_grant", 32'(grant), 32'd0);

    // Round robin with all requests held, single-word bursts
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    modelState = SEED;
    applyStimulus(4'b1111, 16'h1111, 1'b0, 16'h0000);
    for (int g = 0; g < 5; g++) pushBurst(g % 4, 1);
    for (int g = 0; g < 5; g++) begin
      tick();
      checkOutput("rr_busy", 32'(busy), 32'd1);
      checkOutput("rr_grant", 32'(grant), 32'(4'b0001 << (g % 4)));
      if (g == 4) applyStimulus(4'b0000, 16'h1111, 1'b0, 16'h0000);
      tick();
      checkOutput("rr_idle_gap", 32'(busy), 32'd0);
    end
    tick();
    checkOutput("rr_no_extra", 32'(busy), 32'd0);
    checkOutput("rr_queue", 32'(sbq.size()), 32'd0);

    // Table of arbitration / length vectors
    for (int t = 0; t < 6; t++) begin
      applyStimulus(vecs[t].reqMask, vecs[t].lenVec, 1'b0, 16'h0000);
      pushBurst(vecs[t].expId, vecs[t].expLen);
      v0 = validCount;
      d0 = doneCount;
      tick();
      checkOutput("vec_grant", 32'(grant), 32'(4'b0001 << vecs[t].expId));
      applyStimulus(4'b0000, vecs[t].lenVec, 1'b0, 16'h0000);
      drainQueue("vec_drain");
      tick();
      checkOutput("vec_idle", 32'(busy), 32'd0);
      checkOutput("vec_words", 32'(validCount - v0), 32'(vecs[t].expLen));
      checkOutput("vec_dones", 32'(doneCount - d0), 32'd1);
    end

    // Zero seed with simultaneous request: seed wins, grant follows
    applyStimulus(4'b0010, 16'h0030, 1'b1, 16'h0000);
    tick();
    checkOutput("seed0_busy", 32'(busy), 32'd0);
    checkOutput("seed0_grant", 32'(grant), 32'd0);
    checkOutput("seed0_state", 32'(q_data), 32'hACE1);
    applyStimulus(4'b0010, 16'h0030, 1'b0, 16'h0000);
    modelState = SEED;
    pushBurst(1, 3);
    tick();
    checkOutput("seed0_grant1", 32'(grant), 32'b0010);
    checkOutput("seed0_first", 32'(q_data), 32'hACE1);
    applyStimulus(4'b0000, 16'h0030, 1'b1, 16'h1234);
    tick();
    applyStimulus(4'b0000, 16'h0030, 1'b0, 16'h0000);
    drainQueue("seed_ignored_drain");
    tick();
    checkOutput("seed_ignored_state", 32'(q_data), 32'(modelState));

    // Seed 0001 followed by a two-word burst
    applyStimulus(4'b0000, 16'h0000, 1'b1, 16'h0001);
    tick();
    checkOutput("seed1_state", 32'(q_data), 32'h0001);
    applyStimulus(4'b0001, 16'h0002, 1'b0, 16'h0000);
    sbq.push_back('{data: 16'h0001, id: 0, last: 1'b0});
    sbq.push_back('{data: 16'hB400, id: 0, last: 1'b1});
    modelState = lfsrStep(16'hB400);
    tick();
    checkOutput("seed1_grant", 32'(grant), 32'b0001);
    applyStimulus(4'b0000, 16'h0002, 1'b0, 16'h0000);
    drainQueue("seed1_drain");
    tick();

    // Reset on the second word of a five-word burst
    applyStimulus(4'b0100, 16'h0500, 1'b0, 16'h0000);
    sbq.push_back('{data: modelState, id: 2, last: 1'b0});
    modelState = lfsrStep(modelState);
    sbq.push_back('{data: modelState, id: 2, last: 1'b0});
    tick();
    applyStimulus(4'b0000, 16'h0500, 1'b0, 16'h0000);
    tick();
    checkOutput("mid_busy_before", 32'(busy), 32'd1);
    RESET = 1'b1;
    tick();
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_grant", 32'(grant), 32'd0);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    checkOutput("mid_rst_q_data", 32'(q_data), 32'hACE1);
    checkOutput("mid_rst_q_id", 32'(q_id), 32'd0);
    checkOutput("mid_rst_queue", 32'(sbq.size()), 32'd0);
    RESET = 1'b0;
    modelState = SEED;
    applyStimulus(4'b1111, 16'h1111, 1'b0, 16'h0000);
    pushBurst(0, 1);
    tick();
    checkOutput("mid_rst_ptr", 32'(grant), 32'b0001);
    applyStimulus(4'b0000, 16'h1111, 1'b0, 16'h0000);
    drainQueue("mid_rst_drain");
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
